// File: rtl/mdu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_issue_ctrl_pkg
// Description : Shared constants for the MDU issue controller: EX md-class
//               opcode encodings, MDU control codes and occupancy FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_issue_ctrl_pkg;

    // MDU MDUCtrl codes
    localparam logic [2:0] c_mdu_mult  = 3'd0;
    localparam logic [2:0] c_mdu_multu = 3'd1;
    localparam logic [2:0] c_mdu_div   = 3'd2;
    localparam logic [2:0] c_mdu_divu  = 3'd3;
    localparam logic [2:0] c_mdu_mtlo  = 3'd4;
    localparam logic [2:0] c_mdu_mthi  = 3'd5;

    // md-class opcode of the instruction in EX
    localparam logic [3:0] c_md_none  = 4'd0;
    localparam logic [3:0] c_md_mult  = 4'd1;
    localparam logic [3:0] c_md_multu = 4'd2;
    localparam logic [3:0] c_md_div   = 4'd3;
    localparam logic [3:0] c_md_divu  = 4'd4;
    localparam logic [3:0] c_md_mthi  = 4'd5;
    localparam logic [3:0] c_md_mtlo  = 4'd6;
    localparam logic [3:0] c_md_mfhi  = 4'd7;
    localparam logic [3:0] c_md_mflo  = 4'd8;

    // Shadow occupancy FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage : mdu_issue_ctrl_pkg
`default_nettype wire

// File: rtl/mdu_issue_ctrl_md_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : md_op_decode
// Description : Pure combinational class decode of an md-class opcode plus
//               the opcode to MDUCtrl mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module md_op_decode
    import mdu_issue_ctrl_pkg::*;
(
    input  logic [3:0] i_op,
    output logic       o_is_long,
    output logic       o_is_mt,
    output logic       o_is_mf,
    output logic       o_is_md,
    output logic       o_is_mul,
    output logic [2:0] o_ctrl
);

    // Classify the opcode and pick the MDU control code it maps to
    always_comb begin
        o_is_long = 1'b0;
        o_is_mt   = 1'b0;
        o_is_mf   = 1'b0;
        o_is_mul  = 1'b0;
        o_ctrl    = 3'd0;
        case (i_op)
            c_md_mult:  begin o_is_long = 1'b1; o_is_mul = 1'b1; o_ctrl = c_mdu_mult;  end
            c_md_multu: begin o_is_long = 1'b1; o_is_mul = 1'b1; o_ctrl = c_mdu_multu; end
            c_md_div:   begin o_is_long = 1'b1; o_ctrl = c_mdu_div;   end
            c_md_divu:  begin o_is_long = 1'b1; o_ctrl = c_mdu_divu;  end
            c_md_mthi:  begin o_is_mt   = 1'b1; o_ctrl = c_mdu_mthi;  end
            c_md_mtlo:  begin o_is_mt   = 1'b1; o_ctrl = c_mdu_mtlo;  end
            c_md_mfhi:  o_is_mf = 1'b1;
            c_md_mflo:  o_is_mf = 1'b1;
            default:    ;
        endcase
        o_is_md = o_is_long | o_is_mt | o_is_mf;
    end

endmodule : md_op_decode
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_issue_ctrl
// Description : EX-stage front end for the multiply/divide unit. Decodes the
//               md-class instruction in EX, issues it to the MDU, tracks MDU
//               occupancy with a shadow FSM/counter to stall later md-class
//               instructions, and returns mfhi/mflo data to the EX result mux.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    input  logic        ex_flush,
    input  logic        mdu_busy,
    input  logic [31:0] mdu_hi,
    input  logic [31:0] mdu_lo,
    output logic        mdu_start,
    output logic        mdu_en,
    output logic [2:0]  mdu_ctrl,
    output logic [31:0] mdu_srca,
    output logic [31:0] mdu_srcb,
    output logic        stall,
    output logic        mf_valid,
    output logic [31:0] mf_data
);

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    md_state_e  r_state;
    logic [3:0] r_cnt;

    logic       w_is_long;
    logic       w_is_mt;
    logic       w_is_mf;
    logic       w_is_md;
    logic       w_is_mul;
    logic [2:0] w_ctrl;
    logic       w_live;
    logic       w_occupied;
    logic       w_issue;

    md_op_decode u_decode (
        .i_op      (in_op),
        .o_is_long (w_is_long),
        .o_is_mt   (w_is_mt),
        .o_is_mf   (w_is_mf),
        .o_is_md   (w_is_md),
        .o_is_mul  (w_is_mul),
        .o_ctrl    (w_ctrl)
    );

    // A flushed EX instruction is dead; an MDU reporting busy keeps us
    // occupied even if the shadow FSM believes it is idle.
    assign w_live     = in_valid & ~ex_flush;
    assign w_occupied = (r_state == ST_RUN) | mdu_busy;
    assign w_issue    = w_live & (w_is_long | w_is_mt) & ~w_occupied;

    assign stall      = w_live & w_is_md & w_occupied;
    assign mdu_start  = w_issue;
    assign mdu_en     = ~ex_flush;
    assign mdu_ctrl   = w_issue ? w_ctrl : 3'd0;
    assign mdu_srca   = in_rs;
    assign mdu_srcb   = in_rt;
    assign mf_valid   = w_live & w_is_mf & ~w_occupied;

    // Select HI or LO for the move-from read path
    always_comb begin
        mf_data = 32'd0;
        if (in_op == c_md_mfhi) begin
            mf_data = mdu_hi;
        end else if (in_op == c_md_mflo) begin
            mf_data = mdu_lo;
        end
    end

    // Shadow occupancy FSM: count down the MDU latency after a long-op issue
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue && w_is_long) begin
                        r_cnt   <= w_is_mul ? c_mult_cnt : c_div_cnt;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule : mdu_issue_ctrl
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_issue_ctrl
// Description : Scoreboard bench for mdu_issue_ctrl with a small behavioural
//               MDU that updates hi/lo on the issue edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_issue_ctrl;

    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3,
                           DIVU = 4'd4, MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7,
                           MFLO = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_rs, in_rt;
    logic        ex_flush;
    logic        mdu_busy;
    logic [31:0] mdu_hi, mdu_lo;
    logic        mdu_start, mdu_en, stall, mf_valid;
    logic [2:0]  mdu_ctrl;
    logic [31:0] mdu_srca, mdu_srcb, mf_data;

    typedef struct packed {
        logic        start;
        logic        en;
        logic [2:0]  ctrl;
        logic        stall;
        logic        mfv;
        logic [31:0] mfd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .ex_flush  (ex_flush),
        .mdu_busy  (mdu_busy),
        .mdu_hi    (mdu_hi),
        .mdu_lo    (mdu_lo),
        .mdu_start (mdu_start),
        .mdu_en    (mdu_en),
        .mdu_ctrl  (mdu_ctrl),
        .mdu_srca  (mdu_srca),
        .mdu_srcb  (mdu_srcb),
        .stall     (stall),
        .mf_valid  (mf_valid),
        .mf_data   (mf_data)
    );

    // Behavioural MDU: results land in hi/lo at the issue edge
    always @(posedge clk) begin
        if (mdu_start && mdu_en) begin
            case (mdu_ctrl)
                3'd0: {mdu_hi, mdu_lo} <= $signed(mdu_srca) * $signed(mdu_srcb);
                3'd1: {mdu_hi, mdu_lo} <= {32'd0, mdu_srca} * {32'd0, mdu_srcb};
                3'd2: begin
                    mdu_lo <= $signed(mdu_srca) / $signed(mdu_srcb);
                    mdu_hi <= $signed(mdu_srca) % $signed(mdu_srcb);
                end
                3'd3: begin
                    mdu_lo <= mdu_srca / mdu_srcb;
                    mdu_hi <= mdu_srca % mdu_srcb;
                end
                3'd4: mdu_lo <= mdu_srca;
                3'd5: mdu_hi <= mdu_srca;
                default: ;
            endcase
        end
    end

    // Monitor: every cycle the DUT presents a response, compare to scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (mdu_start !== e.start || mdu_en !== e.en || mdu_ctrl !== e.ctrl ||
                stall !== e.stall || mf_valid !== e.mfv || mf_data !== e.mfd ||
                mdu_srca !== in_rs || mdu_srcb !== in_rt) begin
                n_err++;
                $display("FAIL vec%0d: got start=%b en=%b ctrl=%0d stall=%b mfv=%b mfd=%h srca=%h srcb=%h; want start=%b en=%b ctrl=%0d stall=%b mfv=%b mfd=%h srca=%h srcb=%h",
                         n_vec, mdu_start, mdu_en, mdu_ctrl, stall, mf_valid, mf_data,
                         mdu_srca, mdu_srcb, e.start, e.en, e.ctrl, e.stall, e.mfv,
                         e.mfd, in_rs, in_rt);
            end
        end
    end

    // Drive one EX cycle and record the expected combinational response
    task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl,
                       input logic es, input logic een, input logic [2:0] ec,
                       input logic est, input logic emv, input logic [31:0] emd);
        exp_t e;
        in_valid = v;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        ex_flush = fl;
        e.start = es; e.en = een; e.ctrl = ec; e.stall = est; e.mfv = emv; e.mfd = emd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = NONE;
        in_rs    = 32'd0;
        in_rt    = 32'd0;
        ex_flush = 1'b0;
        mdu_busy = 1'b0;
        mdu_hi   = 32'd0;
        mdu_lo   = 32'd0;
        @(posedge clk);
        #1;

        // Reset state
        cyc(0, NONE, 0, 0, 0,  0, 1, 0, 0, 0, 32'd0);
        cyc(0, NONE, 0, 0, 0,  0, 1, 0, 0, 0, 32'd0);
        reset = 1'b0;

        // MULT 7 * -3, then MFLO held: stalled T+1..T+5, read at T+6
        cyc(1, MULT, 32'd7, 32'hFFFF_FFFD, 0,  1, 1, 3'd0, 0, 0, 32'd0);
        for (int i = 0; i < 5; i++)
            cyc(1, MFLO, 0, 0, 0,  0, 1, 0, 1, 0, 32'hFFFF_FFEB);
        cyc(1, MFLO, 0, 0, 0,  0, 1, 0, 0, 1, 32'hFFFF_FFEB);
        cyc(0, NONE, 0, 0, 0,  0, 1, 0, 0, 0, 32'd0);

        // DIV 100/7 then DIVU 9/2: second op stalled exactly 10 cycles
        cyc(1, DIV, 32'd100, 32'd7, 0,  1, 1, 3'd2, 0, 0, 32'd0);
        for (int i = 0; i < 10; i++)
            cyc(1, DIVU, 32'd9, 32'd2, 0,  0, 1, 0, 1, 0, 32'd0);
        cyc(1, DIVU, 32'd9, 32'd2, 0,  1, 1, 3'd3, 0, 0, 32'd0);
        // Non-md ops during RUN are never stalled; counter keeps its schedule
        for (int i = 0; i < 9; i++)
            cyc(1, NONE, 32'd1, 32'd1, 0,  0, 1, 0, 0, 0, 32'd0);
        cyc(1, MFLO, 0, 0, 0,  0, 1, 0, 1, 0, 32'd4);
        cyc(1, MFLO, 0, 0, 0,  0, 1, 0, 0, 1, 32'd4);

        // MTHI while idle, then MFHI immediately
        cyc(1, MTHI, 32'h1234, 0, 0,  1, 1, 3'd5, 0, 0, 32'd0);
        cyc(1, MFHI, 0, 0, 0,  0, 1, 0, 0, 1, 32'h1234);

        // Flushed MULT: nothing issued, FSM stays idle, MFLO not stalled
        cyc(1, MULT, 32'd5, 32'd5, 1,  0, 0, 0, 0, 0, 32'd0);
        cyc(1, MFLO, 0, 0, 0,  0, 1, 0, 0, 1, 32'd4);

        // DIV 50/5, flush during RUN, then reset at RUN cycle 3
        cyc(1, DIV, 32'd50, 32'd5, 0,  1, 1, 3'd2, 0, 0, 32'd0);
        cyc(1, MFLO, 0, 0, 1,  0, 0, 0, 0, 0, 32'd10);
        cyc(1, MFLO, 0, 0, 0,  0, 1, 0, 1, 0, 32'd10);
        reset = 1'b1;
        cyc(0, NONE, 0, 0, 0,  0, 1, 0, 0, 0, 32'd0);
        reset = 1'b0;
        cyc(1, MULT, 32'd3, 32'd4, 0,  1, 1, 3'd0, 0, 0, 32'd0);
        for (int i = 0; i < 5; i++)
            cyc(1, MFLO, 0, 0, 0,  0, 1, 0, 1, 0, 32'd12);
        cyc(1, MFLO, 0, 0, 0,  0, 1, 0, 0, 1, 32'd12);

        // MDU reports busy while FSM idle: stall until busy falls
        mdu_busy = 1'b1;
        cyc(1, MTLO, 32'hAA, 0, 0,  0, 1, 0, 1, 0, 32'd0);
        mdu_busy = 1'b0;
        cyc(1, MTLO, 32'hAA, 0, 0,  1, 1, 3'd4, 0, 0, 32'd0);
        cyc(1, MFLO, 0, 0, 0,  0, 1, 0, 0, 1, 32'hAA);
        cyc(0, NONE, 0, 0, 0,  0, 1, 0, 0, 0, 32'd0);

        // Allow the monitor a bounded window to drain the scoreboard
        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mdu_issue_ctrl
`default_nettype wire
